dev_bridge: RTL and testbench

- System bridge between the CPU memory-stage data port and memory-mapped peripherals, e.g. timers, at BASE and above.
- Decodes device accesses and sequences a request/acknowledge handshake with the selected device.
- Stalls the pipeline until the access completes or times out, and returns read data.
- Synchronises device interrupt lines into the CP0 hardware-interrupt vector.

---
 rtl/dev_bridge_pkg.sv | 15 +
 rtl/dev_bridge_if.sv | 42 ++++
 rtl/dev_bridge_irq_sync.sv | 26 ++
 rtl/dev_bridge.sv | 161 ++++++++++++++++
 tb/tb_dev_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM encoding,
// device window base and hardware-interrupt vector width.
package dev_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEV_BASE = 32'h0000_7f00;
  localparam int          DEV_MAX  = 6;

endpackage

// File: rtl/dev_bridge_if.sv
// Bundles the CPU data-port and peripheral-bus signals of the bridge.
// master is the bridge side, slave is the CPU/device environment.
interface dev_bridge_if
  import dev_bridge_pkg::*;
#(
  parameter int NDEV      = 2,
  parameter int SPAN_LOG2 = 4
);

  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic                 cpu_we;
  logic                 cpu_re;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;
  logic                 cpu_buserr;

  logic [NDEV-1:0]      dev_sel;
  logic [SPAN_LOG2-3:0] dev_addr;
  logic [31:0]          dev_wdata;
  logic                 dev_we;
  logic                 dev_req;
  logic [NDEV-1:0]      dev_ack;
  logic [32*NDEV-1:0]   dev_rdata;
  logic [NDEV-1:0]      dev_irq;
  logic [DEV_MAX-1:0]   hwint;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  dev_ack, dev_rdata, dev_irq,
    output cpu_rdata, cpu_stall, cpu_buserr,
    output dev_sel, dev_addr, dev_wdata, dev_we, dev_req, hwint
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output dev_ack, dev_rdata, dev_irq,
    input  cpu_rdata, cpu_stall, cpu_buserr,
    input  dev_sel, dev_addr, dev_wdata, dev_we, dev_req, hwint
  );

endinterface

// File: rtl/dev_bridge_irq_sync.sv
// Two-flop synchroniser for asynchronous level interrupt lines.
module irq_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/dev_bridge.sv
// Memory-stage bridge: decodes the device window, runs a req/ack handshake
// with a timeout, stalls the pipeline meanwhile and forwards device IRQs.
module dev_bridge
  import dev_bridge_pkg::*;
#(
  parameter int          NDEV      = 2,
  parameter logic [31:0] BASE      = DEV_BASE,
  parameter int          SPAN_LOG2 = 4,
  parameter int          TIMEOUT   = 15
) (
  input logic       clk,
  input logic       reset,
  dev_bridge_if.master bus
);

  localparam int          CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int          AW      = SPAN_LOG2 - 2;
  localparam logic [31:0] DEV_END = 32'(NDEV) << SPAN_LOG2;
  localparam logic [31:0] WIN_END = 32'(DEV_MAX) << SPAN_LOG2;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t          state_reg, state_next;
  logic [NDEV-1:0] sel_reg, sel_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic            we_reg, we_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [31:0]     rdata_reg, rdata_next;

  logic            access, above, hit, nodev;
  logic [31:0]     offset;
  logic [2:0]      idx;
  logic [NDEV-1:0] sel_dec;
  logic            ack_sel;
  logic [31:0]     rdata_sel;
  logic [31:0]     slice_masked [NDEV];
  logic            stall, buserr, req;
  logic [NDEV-1:0] irq_q;

  // Decode: offset compares run on the full 32 bits so wrap-around cannot alias.
  assign access = bus.cpu_we | bus.cpu_re;
  assign above  = bus.cpu_addr >= BASE;
  assign offset = bus.cpu_addr - BASE;
  assign hit    = access && above && (offset < DEV_END);
  assign nodev  = access && above && (offset >= DEV_END) && (offset < WIN_END);
  assign idx    = offset[SPAN_LOG2+2:SPAN_LOG2];

  for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
    assign sel_dec[gi]      = (idx == 3'(gi));
    assign slice_masked[gi] = bus.dev_rdata[32*gi +: 32] & {32{sel_reg[gi]}};
  end

  assign ack_sel = |(bus.dev_ack & sel_reg);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      rdata_sel = rdata_sel | slice_masked[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    stall      = 1'b0;
    buserr     = 1'b0;
    req        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          stall      = 1'b1;
          sel_next   = sel_dec;
          addr_next  = offset[SPAN_LOG2-1:2];
          wdata_next = bus.cpu_wdata;
          we_next    = bus.cpu_we;
          cnt_next   = '0;
          state_next = REQ;
        end else if (nodev) begin
          buserr = 1'b1;
        end
      end
      REQ: begin
        stall      = 1'b1;
        req        = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        stall    = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        // An ack arriving on the timeout cycle still completes normally.
        if (ack_sel) begin
          rdata_next = rdata_sel;
          state_next = DONE;
        end else if (cnt_reg == CNT_MAX) begin
          buserr     = 1'b1;
          rdata_next = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        // The retiring instruction's access lines are ignored here.
        sel_next   = '0;
        addr_next  = '0;
        wdata_next = '0;
        we_next    = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cpu_stall  = stall;
  assign bus.cpu_buserr = buserr;
  assign bus.cpu_rdata  = rdata_reg;
  assign bus.dev_req    = req;
  assign bus.dev_sel    = sel_reg;
  assign bus.dev_addr   = addr_reg;
  assign bus.dev_wdata  = wdata_reg;
  assign bus.dev_we     = we_reg;

  irq_sync #(.W(NDEV)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.dev_irq),
    .q     (irq_q)
  );

  for (genvar gi = 0; gi < DEV_MAX; gi++) begin : g_hwint
    if (gi < NDEV) begin : g_used
      assign bus.hwint[gi] = irq_q[gi];
    end else begin : g_unused
      assign bus.hwint[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_dev_bridge.sv
// Scoreboarded bench for dev_bridge: expectations are queued per access and
// checked by a negedge monitor when the access completes.
module tb_dev_bridge;
  import dev_bridge_pkg::*;

  localparam int          NDEV      = 2;
  localparam int          SPAN_LOG2 = 4;
  localparam int          TIMEOUT   = 15;
  localparam logic [31:0] BASE      = 32'h0000_7f00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dev_bridge_if #(.NDEV(NDEV), .SPAN_LOG2(SPAN_LOG2)) bus ();

  dev_bridge #(.NDEV(NDEV), .BASE(BASE), .SPAN_LOG2(SPAN_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          stall;
    int          req;
    logic [1:0]  sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          berr;
    int          berr_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] slice [NDEV];

  assign bus.dev_rdata = {slice[1], slice[0]};

  // Reference model of one access, written from the address map and timing rules.
  function automatic exp_t predict(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic we, input logic re, input int ack_after);
    exp_t e = '{default: 0};
    logic acc = we | re;
    logic hit = acc && addr >= BASE && addr < BASE + NDEV * 16;
    logic nod = acc && addr >= BASE + NDEV * 16 && addr < BASE + 6 * 16;
    int   idx;
    if (hit) begin
      idx     = int'((addr - BASE) >> 4);
      e.req   = 1;
      e.sel   = 2'(1 << idx);
      e.addr  = 2'((addr - BASE) >> 2);
      e.wdata = wdata;
      e.we    = we;
      if (ack_after >= 1 && ack_after <= TIMEOUT + 1) begin
        e.stall = 2 + ack_after;
        e.rdata = slice[idx];
      end else begin
        e.stall    = TIMEOUT + 3;
        e.rdata    = 32'h0;
        e.berr     = 1;
        e.berr_cyc = TIMEOUT + 2;
      end
    end else if (nod) begin
      e.berr     = 1;
      e.berr_cyc = 0;
    end
    return e;
  endfunction

  // Monitor: measures each access from its first active cycle to the first unstalled one.
  bit          mon_active = 0;
  int          m_cyc, m_stall, m_req, m_berr, m_berr_cyc;
  logic [1:0]  m_sel, m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  exp_t        e_pop;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 0;
    end else begin
      if (!mon_active && (bus.cpu_we || bus.cpu_re)) begin
        mon_active = 1; m_cyc = 0; m_stall = 0; m_req = 0; m_berr = 0; m_berr_cyc = -1;
      end
      if (mon_active) begin
        if (bus.cpu_stall) m_stall++;
        if (bus.dev_req) begin
          m_req++; m_sel = bus.dev_sel; m_addr = bus.dev_addr;
          m_wdata = bus.dev_wdata; m_we = bus.dev_we;
        end
        if (bus.cpu_buserr) begin m_berr++; m_berr_cyc = m_cyc; end
        if (!bus.cpu_stall) begin
          mon_active = 0;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_empty: access completed with no expectation queued");
          end else begin
            e_pop = exp_q.pop_front();
            $display("[TB] access done: stall=%0d req=%0d berr=%0d@%0d rdata=%08h",
                     m_stall, m_req, m_berr, m_berr_cyc, bus.cpu_rdata);
            if (m_stall !== e_pop.stall) begin
              tests_failed++; $display("FAIL stall_cycles: got %0d expected %0d", m_stall, e_pop.stall);
            end
            tests_run++;
            if (m_req !== e_pop.req) begin
              tests_failed++; $display("FAIL req_count: got %0d expected %0d", m_req, e_pop.req);
            end
            tests_run++;
            if (m_berr !== e_pop.berr) begin
              tests_failed++; $display("FAIL buserr_count: got %0d expected %0d", m_berr, e_pop.berr);
            end
            if (e_pop.berr != 0) begin
              tests_run++;
              if (m_berr_cyc !== e_pop.berr_cyc) begin
                tests_failed++; $display("FAIL buserr_cycle: got %0d expected %0d", m_berr_cyc, e_pop.berr_cyc);
              end
            end
            if (e_pop.req != 0) begin
              tests_run++;
              if ({m_sel, m_addr, m_we} !== {e_pop.sel, e_pop.addr, e_pop.we}) begin
                tests_failed++;
                $display("FAIL sel_addr_we: got %b/%0d/%b expected %b/%0d/%b",
                         m_sel, m_addr, m_we, e_pop.sel, e_pop.addr, e_pop.we);
              end
              tests_run++;
              if (m_wdata !== e_pop.wdata) begin
                tests_failed++; $display("FAIL dev_wdata: got %08h expected %08h", m_wdata, e_pop.wdata);
              end
              tests_run++;
              if (bus.cpu_rdata !== e_pop.rdata) begin
                tests_failed++; $display("FAIL cpu_rdata: got %08h expected %08h", bus.cpu_rdata, e_pop.rdata);
              end
            end
          end
        end
        m_cyc++;
      end
    end
  end

  // Drives one access; the selected device acks in WAIT cycle ack_after (0 = never).
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic re, input int ack_dev, input int ack_after,
                       input logic [1:0] noise);
    int waitk = 0;
    bit seen_req = 0;
    bit done = 0;
    @(posedge clk); #2;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_we = we; bus.cpu_re = re;
    #1;
    if (bus.cpu_stall) begin
      for (int n = 0; n < TIMEOUT + 10 && !done; n++) begin
        @(posedge clk); #2;
        bus.dev_ack = noise;
        if (seen_req) begin
          waitk++;
          if (waitk == ack_after) bus.dev_ack = noise | 2'(1 << ack_dev);
        end
        if (bus.dev_req) seen_req = 1;
        #1;
        if (!bus.cpu_stall) done = 1;
      end
      if (!done) begin
        tests_run++; tests_failed++;
        $display("FAIL drive_budget: stall still %b after %0d cycles, expected 0", bus.cpu_stall, TIMEOUT + 10);
      end
    end
    @(posedge clk); #2;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.dev_ack = '0;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    tests_run++;
    if ({bus.cpu_stall, bus.cpu_buserr, bus.dev_req, bus.dev_we} !== 4'b0 ||
        bus.dev_sel !== 2'b0 || bus.dev_addr !== 2'b0 || bus.dev_wdata !== 32'h0 ||
        bus.cpu_rdata !== 32'h0 || bus.hwint !== 6'h0) begin
      tests_failed++;
      $display("FAIL reset_state: stall/err/req/we=%b%b%b%b sel=%b rdata=%08h hwint=%b expected all 0",
               bus.cpu_stall, bus.cpu_buserr, bus.dev_req, bus.dev_we, bus.dev_sel, bus.cpu_rdata, bus.hwint);
    end
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic test_write_fast();
    slice[0] = 32'h0102_0304; slice[1] = 32'h1111_2222;
    exp_q.push_back(predict(32'h7f04, 32'hDEAD_BEEF, 1'b1, 1'b0, 1));
    drive(32'h7f04, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1, 2'b00);
    tests_run++;
    if ({bus.cpu_stall, bus.dev_req, bus.dev_we} !== 3'b0 || bus.dev_sel !== 2'b0 || bus.dev_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_cleanup: stall/req/we=%b%b%b sel=%b wdata=%08h expected 0",
               bus.cpu_stall, bus.dev_req, bus.dev_we, bus.dev_sel, bus.dev_wdata);
    end
  endtask

  task automatic test_read_delayed();
    slice[0] = 32'hAAAA_5555; slice[1] = 32'h0000_1234;
    exp_q.push_back(predict(32'h7f18, 32'h0, 1'b0, 1'b1, 4));
    drive(32'h7f18, 32'h0, 1'b0, 1'b1, 1, 4, 2'b00);
  endtask

  task automatic test_timeout();
    slice[1] = 32'hCAFE_F00D;
    exp_q.push_back(predict(32'h7f10, 32'h0, 1'b0, 1'b1, 0));
    drive(32'h7f10, 32'h0, 1'b0, 1'b1, 1, 0, 2'b00);
    tests_run++;
    if (bus.cpu_stall !== 1'b0 || bus.dev_req !== 1'b0 || bus.cpu_buserr !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_idle: stall=%b req=%b buserr=%b expected 0", bus.cpu_stall, bus.dev_req, bus.cpu_buserr);
    end
    // Ack on the same cycle the counter reaches its limit must win.
    slice[1] = 32'h7777_8888;
    exp_q.push_back(predict(32'h7f14, 32'h0, 1'b0, 1'b1, TIMEOUT + 1));
    drive(32'h7f14, 32'h0, 1'b0, 1'b1, 1, TIMEOUT + 1, 2'b00);
  endtask

  task automatic test_decode();
    logic [31:0] addrs [4] = '{32'h7efc, 32'h7f20, 32'h7f5c, 32'h7f60};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(predict(addrs[i], 32'h5A5A_0000 + 32'(i), 1'b1, 1'b0, 1));
      drive(addrs[i], 32'h5A5A_0000 + 32'(i), 1'b1, 1'b0, 0, 1, 2'b00);
    end
  endtask

  task automatic test_ignore_other_ack();
    slice[0] = 32'h0BAD_F00D; slice[1] = 32'hFFFF_FFFF;
    exp_q.push_back(predict(32'h7f0c, 32'h0, 1'b0, 1'b1, 2));
    drive(32'h7f0c, 32'h0, 1'b0, 1'b1, 0, 2, 2'b10);
  endtask

  task automatic test_back_to_back();
    slice[0] = 32'h1357_9BDF; slice[1] = 32'h2468_ACE0;
    exp_q.push_back(predict(32'h7f08, 32'h8765_4321, 1'b1, 1'b1, 1));
    drive(32'h7f08, 32'h8765_4321, 1'b1, 1'b1, 0, 1, 2'b00);
    exp_q.push_back(predict(32'h7f1c, 32'h0, 1'b0, 1'b1, 3));
    drive(32'h7f1c, 32'h0, 1'b0, 1'b1, 1, 3, 2'b00);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bus.dev_irq = 2'b01;
    slice[1] = 32'h5555_AAAA;
    @(posedge clk); #2;
    bus.cpu_addr = 32'h7f10; bus.cpu_re = 1'b1;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(posedge clk); #2;
      if (bus.dev_req) seen = 1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL reset_mid_req: dev_req got 0 expected 1"); end
    @(posedge clk); #2;
    @(posedge clk); #3;
    reset = 1'b1; bus.cpu_re = 1'b0; bus.dev_irq = 2'b00;
    #1;
    tests_run++;
    if ({bus.cpu_stall, bus.cpu_buserr, bus.dev_req, bus.dev_we} !== 4'b0 || bus.dev_sel !== 2'b0 ||
        bus.dev_addr !== 2'b0 || bus.dev_wdata !== 32'h0 || bus.cpu_rdata !== 32'h0 || bus.hwint !== 6'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: stall/err/req/we=%b%b%b%b sel=%b rdata=%08h hwint=%b expected all 0",
               bus.cpu_stall, bus.cpu_buserr, bus.dev_req, bus.dev_we, bus.dev_sel, bus.cpu_rdata, bus.hwint);
    end
    @(posedge clk); #2;
    reset = 1'b0; bus.dev_ack = 2'b10;
    @(posedge clk); #2;
    bus.dev_ack = 2'b00;
    #1;
    tests_run++;
    if (bus.cpu_rdata !== 32'h0 || bus.cpu_stall !== 1'b0 || bus.dev_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_ack: rdata=%08h stall=%b req=%b expected 0/0/0", bus.cpu_rdata, bus.cpu_stall, bus.dev_req);
    end
    exp_q.push_back(predict(32'h7f00, 32'h0, 1'b0, 1'b1, 1));
    drive(32'h7f00, 32'h0, 1'b0, 1'b1, 0, 1, 2'b00);
  endtask

  task automatic test_irq();
    logic [5:0] want [4] = '{6'b000000, 6'b000010, 6'b000010, 6'b000000};
    exp_q.push_back(predict(32'h7f10, 32'h0, 1'b0, 1'b1, 0));
    fork
      drive(32'h7f10, 32'h0, 1'b0, 1'b1, 1, 0, 2'b00);
      begin
        repeat (3) @(posedge clk);
        #2 bus.dev_irq = 2'b10;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          tests_run++;
          if (bus.hwint !== want[k]) begin
            tests_failed++; $display("FAIL hwint_edge%0d: got %b expected %b", k + 1, bus.hwint, want[k]);
          end
          if (k == 1) bus.dev_irq = 2'b00;
        end
      end
    join
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    bus.dev_ack = '0; bus.dev_irq = '0;
    slice[0] = '0; slice[1] = '0;
    test_reset();
    test_write_fast();
    test_read_delayed();
    test_timeout();
    test_decode();
    test_ignore_other_ack();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    repeat (2) @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL sb_leftover: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
